// File: rtl/traffic_light_timed_controller.sv
// Timed highway/country-road intersection controller.
// A six-phase Moore machine drives both light heads from the registered
// phase only; the country sensor X affects nothing but the next phase.
// Each phase has a saturating elapsed-cycle counter that restarts whenever
// the phase changes, and all timing decisions are taken from that counter.
module traffic_light_timed_controller #(
   parameter int CNT_W           = 8,
   parameter int HWY_MIN_GREEN   = 20,
   parameter int YELLOW_TIME     = 4,
   parameter int ALL_RED_TIME    = 2,
   parameter int CNTRY_MIN_GREEN = 5,
   parameter int CNTRY_MAX_GREEN = 15
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             X,
   output logic [1:0]       hwy,
   output logic [1:0]       cntry,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] elapsed
);

   typedef enum logic [2:0] {
      HG  = 3'd0,
      HY  = 3'd1,
      AR1 = 3'd2,
      CG  = 3'd3,
      CY  = 3'd4,
      AR2 = 3'd5
   } state_e;

   localparam logic [1:0] RED    = 2'd0;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] GREEN  = 2'd2;

   // Last elapsed value of each phase (durations are counted from zero).
   localparam logic [CNT_W-1:0] HWY_MIN_LAST = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(ALL_RED_TIME - 1);
   localparam logic [CNT_W-1:0] CMIN_LAST    = CNT_W'(CNTRY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] CMAX_LAST    = CNT_W'(CNTRY_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] CNT_SAT      = '1;

   // The state register is kept as a plain 3-bit vector so that the two
   // unused codes can exist and be recovered from.
   logic [2:0]       state_q;
   state_e           state_d;
   logic [CNT_W-1:0] elapsed_q;
   logic [CNT_W-1:0] elapsed_d;

   // Phase sequencing: each phase leaves on its own elapsed/sensor rule,
   // and any unused code falls back to highway green.
   always_comb begin
      state_d = state_e'(state_q);
      case (state_q)
         HG:  if (X && (elapsed_q >= HWY_MIN_LAST))   state_d = HY;
         HY:  if (elapsed_q == YELLOW_LAST)           state_d = AR1;
         AR1: if (elapsed_q == ALL_RED_LAST)          state_d = CG;
         CG:  if ((!X && (elapsed_q >= CMIN_LAST)) ||
                  (elapsed_q == CMAX_LAST))           state_d = CY;
         CY:  if (elapsed_q == YELLOW_LAST)           state_d = AR2;
         AR2: if (elapsed_q == ALL_RED_LAST)          state_d = HG;
         default:                                     state_d = HG;
      endcase
   end

   // Elapsed counter restarts on entry to a new phase and sticks at its
   // maximum while a phase (normally highway green) is held indefinitely.
   always_comb begin
      elapsed_d = elapsed_q;
      if (state_d != state_q) begin
         elapsed_d = '0;
      end else if (elapsed_q != CNT_SAT) begin
         elapsed_d = elapsed_q + CNT_W'(1);
      end
   end

   // State and counter registers; clear overrides any pending transition.
   always_ff @(posedge clk) begin
      if (clear) begin
         state_q   <= HG;
         elapsed_q <= '0;
      end else begin
         state_q   <= state_d;
         elapsed_q <= elapsed_d;
      end
   end

   // Light decoding from the registered phase only; unused codes show
   // highway green so the intersection never goes dark or conflicting.
   always_comb begin
      hwy   = GREEN;
      cntry = RED;
      case (state_q)
         HG:  begin hwy = GREEN;  cntry = RED;    end
         HY:  begin hwy = YELLOW; cntry = RED;    end
         AR1: begin hwy = RED;    cntry = RED;    end
         CG:  begin hwy = RED;    cntry = GREEN;  end
         CY:  begin hwy = RED;    cntry = YELLOW; end
         AR2: begin hwy = RED;    cntry = RED;    end
         default: begin hwy = GREEN; cntry = RED; end
      endcase
   end

   assign phase   = state_q;
   assign elapsed = elapsed_q;

endmodule

// File: tb/tb_traffic_light_timed_controller.sv
// Self-checking bench for traffic_light_timed_controller with short
// phase durations. A phase/elapsed reference model follows the timing
// rules directly; a vector table covers the full request cycle and short
// hand sequences cover minimum/maximum greens, reset and illegal codes.
module tb_traffic_light_timed_controller;

   localparam int CNT_W = 8;
   localparam int HMG   = 5;
   localparam int YT    = 2;
   localparam int ART   = 1;
   localparam int CMIN  = 3;
   localparam int CMAX  = 6;
   localparam int SAT   = (1 << CNT_W) - 1;

   logic             clk   = 1'b0;
   logic             clear = 1'b1;
   logic             X     = 1'b0;
   logic [1:0]       hwy;
   logic [1:0]       cntry;
   logic [2:0]       phase;
   logic [CNT_W-1:0] elapsed;

   int total = 0;
   int bad   = 0;

   int mPhase = 0;
   int mEl    = 0;

   int hwyOf[8]   = '{2, 1, 0, 0, 0, 0, 2, 2};
   int cntryOf[8] = '{0, 0, 0, 2, 1, 0, 0, 0};
   int dur[6]     = '{HMG, YT, ART, CMAX, YT, ART};

   typedef struct {
      bit clr;
      bit x;
      int ePhase;
      int eHwy;
      int eCntry;
      int eEl;
   } vec_t;

   vec_t vecs[$];

   traffic_light_timed_controller #(
      .CNT_W(CNT_W),
      .HWY_MIN_GREEN(HMG),
      .YELLOW_TIME(YT),
      .ALL_RED_TIME(ART),
      .CNTRY_MIN_GREEN(CMIN),
      .CNTRY_MAX_GREEN(CMAX)
   ) dut (
      .clk(clk),
      .clear(clear),
      .X(X),
      .hwy(hwy),
      .cntry(cntry),
      .phase(phase),
      .elapsed(elapsed)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   task automatic checkVal(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Advance the reference model by one clock edge.
   task automatic modelStep(input bit c, input bit x);
      bit adv;
      adv = 1'b0;
      if (c) begin
         mPhase = 0;
         mEl    = 0;
      end else begin
         case (mPhase)
            0:       adv = x && (mEl >= HMG - 1);
            1:       adv = (mEl == YT - 1);
            2:       adv = (mEl == ART - 1);
            3:       adv = (!x && (mEl >= CMIN - 1)) || (mEl == CMAX - 1);
            4:       adv = (mEl == YT - 1);
            5:       adv = (mEl == ART - 1);
            default: adv = 1'b1;
         endcase
         if (adv) begin
            mPhase = (mPhase >= 5) ? 0 : mPhase + 1;
            mEl    = 0;
         end else begin
            mEl = (mEl >= SAT) ? SAT : mEl + 1;
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      checkVal({tag, " phase"},   int'(phase),   mPhase);
      checkVal({tag, " hwy"},     int'(hwy),     hwyOf[mPhase]);
      checkVal({tag, " cntry"},   int'(cntry),   cntryOf[mPhase]);
      checkVal({tag, " elapsed"}, int'(elapsed), mEl);
      checkVal({tag, " safety"}, ((hwy != 2'd0) && (cntry != 2'd0)) ? 1 : 0, 0);
   endtask

   // Drive inputs on the falling edge, then check just after the rising edge.
   task automatic applyStimulus(input bit c, input bit x, input string tag);
      @(negedge clk);
      clear = c;
      X     = x;
      @(posedge clk);
      modelStep(c, x);
      #1;
      checkOutput(tag);
   endtask

   // Hold X high until country green starts, bounded by a cycle budget.
   task automatic runToCg(input int budget);
      for (int i = 0; i < budget && phase != 3'd3; i++) begin
         applyStimulus(1'b0, 1'b1, "toCg");
      end
      checkVal("reach CG", (phase == 3'd3) ? 1 : 0, 1);
   endtask

   task automatic addVec(input bit c, input bit x, input int p, input int e);
      vec_t v;
      v.clr    = c;
      v.x      = x;
      v.ePhase = p;
      v.eHwy   = hwyOf[p];
      v.eCntry = cntryOf[p];
      v.eEl    = e;
      vecs.push_back(v);
   endtask

   initial begin
      // Full request cycle with X held high: two complete 17-cycle rounds.
      addVec(1'b1, 1'b1, 0, 0);
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < 6; p++) begin
            for (int e = 0; e < dur[p]; e++) begin
               if (!(r == 0 && p == 0 && e == 0)) addVec(1'b0, 1'b1, p, e);
            end
         end
      end
      addVec(1'b0, 1'b1, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].clr, vecs[i].x, "vec");
         checkVal("vec phase",   int'(phase),   vecs[i].ePhase);
         checkVal("vec hwy",     int'(hwy),     vecs[i].eHwy);
         checkVal("vec cntry",   int'(cntry),   vecs[i].eCntry);
         checkVal("vec elapsed", int'(elapsed), vecs[i].eEl);
      end

      // No request: highway green holds, then a request is honoured at once.
      applyStimulus(1'b1, 1'b0, "rst");
      repeat (40) applyStimulus(1'b0, 1'b0, "idle");
      checkVal("idle40 phase",   int'(phase),   0);
      checkVal("idle40 hwy",     int'(hwy),     2);
      checkVal("idle40 cntry",   int'(cntry),   0);
      checkVal("idle40 elapsed", int'(elapsed), 40);
      applyStimulus(1'b0, 1'b1, "raise");
      checkVal("raise phase", int'(phase), 1);

      // X drops at the start of country green: minimum green still served.
      applyStimulus(1'b1, 1'b1, "rst");
      runToCg(30);
      applyStimulus(1'b0, 1'b0, "cgMin");
      applyStimulus(1'b0, 1'b0, "cgMin");
      checkVal("cgMin hold phase",   int'(phase),   3);
      checkVal("cgMin hold elapsed", int'(elapsed), 2);
      applyStimulus(1'b0, 1'b0, "cgMin");
      checkVal("cgMin end phase", int'(phase), 4);

      // X drops at elapsed 4: yellow on the very next edge.
      applyStimulus(1'b1, 1'b1, "rst");
      runToCg(30);
      repeat (4) applyStimulus(1'b0, 1'b1, "cgMid");
      checkVal("cgMid elapsed", int'(elapsed), 4);
      applyStimulus(1'b0, 1'b0, "cgMid");
      checkVal("cgMid end phase", int'(phase), 4);

      // Short request pulse during highway minimum green is not latched.
      applyStimulus(1'b1, 1'b0, "rst");
      applyStimulus(1'b0, 1'b0, "pulse");
      applyStimulus(1'b0, 1'b1, "pulse");
      applyStimulus(1'b0, 1'b1, "pulse");
      repeat (4) applyStimulus(1'b0, 1'b0, "pulse");
      checkVal("pulse phase",   int'(phase),   0);
      checkVal("pulse elapsed", int'(elapsed), 7);

      // Clear in the middle of country green wins over everything.
      applyStimulus(1'b1, 1'b1, "rst");
      runToCg(30);
      repeat (2) applyStimulus(1'b0, 1'b1, "cgClr");
      checkVal("cgClr pre elapsed", int'(elapsed), 2);
      applyStimulus(1'b1, 1'b1, "cgClr");
      checkVal("cgClr phase",   int'(phase),   0);
      checkVal("cgClr hwy",     int'(hwy),     2);
      checkVal("cgClr cntry",   int'(cntry),   0);
      checkVal("cgClr elapsed", int'(elapsed), 0);

      // Elapsed saturates during an unbroken highway green.
      applyStimulus(1'b1, 1'b0, "rst");
      repeat (SAT + 5) applyStimulus(1'b0, 1'b0, "sat");
      checkVal("sat elapsed", int'(elapsed), SAT);
      checkVal("sat phase",   int'(phase),   0);

      // Illegal state code 7 decodes as GREEN/RED and recovers to HG.
      applyStimulus(1'b1, 1'b0, "rst");
      @(negedge clk);
      clear = 1'b0;
      X     = 1'b0;
      force dut.state_q = 3'd7;
      #1;
      checkVal("illegal phase", int'(phase), 7);
      checkVal("illegal hwy",   int'(hwy),   2);
      checkVal("illegal cntry", int'(cntry), 0);
      release dut.state_q;
      @(posedge clk);
      #1;
      checkVal("illegal recover phase", int'(phase), 0);
      applyStimulus(1'b1, 1'b0, "rst");

      // Randomised traffic with occasional clears against the model.
      for (int i = 0; i < 400; i++) begin
         bit c;
         bit x;
         c = ($urandom_range(0, 59) == 0);
         x = ($urandom_range(0, 3) != 0);
         applyStimulus(c, x, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/traffic_light_timed_controller.md
Name: traffic_light_timed_controller

Overview:
- Timed successor of the highway/country-road controller. A single sensor input X (vehicle waiting on the country road) drives a 6-phase Moore FSM.
- Adds what the earlier controller lacks: parametrised phase durations, a highway minimum green, a country minimum and maximum green, and all-red clearance intervals in both directions.
- Sits at the intersection top level. Drives the two light-head encoders directly and exports phase and elapsed time for monitoring.

Parameters:
- CNT_W, 8, width of the phase-elapsed counter; every duration must be ≤ 2^CNT_W.
- HWY_MIN_GREEN, 20, minimum cycles of highway green before a country request is honoured (≥1).
- YELLOW_TIME, 4, yellow duration in cycles for both roads (≥1).
- ALL_RED_TIME, 2, all-red clearance in cycles, used in both directions (≥1).
- CNTRY_MIN_GREEN, 5, minimum country green in cycles (≥1).
- CNTRY_MAX_GREEN, 15, maximum country green in cycles (≥ CNTRY_MIN_GREEN).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- clear  in  1  synchronous, active-high reset.
- X  in  1  country-road vehicle sensor; level-sensitive, synchronous to clk.
- hwy  out  2  highway light: 0=RED, 1=YELLOW, 2=GREEN.
- cntry  out  2  country light, same encoding.
- phase  out  3  current FSM state code.
- elapsed  out  CNT_W  cycles spent in the current phase, starting at 0.

Behaviour:
- Reset: one clock and synchronous active-high reset. clear sampled high at a rising edge forces phase=HG, elapsed=0, hwy=GREEN, cntry=RED, from any state, including mid country-green.
- States, with lights given as hwy/cntry:
  - HG=0: GREEN/RED.
  - HY=1: YELLOW/RED.
  - AR1=2: RED/RED.
  - CG=3: RED/GREEN.
  - CY=4: RED/YELLOW.
  - AR2=5: RED/RED.
- Illegal codes 6 and 7 go to HG on the next edge. The lights decode those codes as GREEN/RED.
- Outputs are a pure function of the registered state. There is no combinational path from X to any output.
- elapsed counter:
  - Cleared to 0 on the edge that enters a new phase.
  - Otherwise increments by 1 each cycle.
  - Saturates at 2^CNT_W−1 and never wraps.
- Transition conditions, evaluated on the current elapsed value and X:
  - HG→HY when elapsed ≥ HWY_MIN_GREEN−1 and X=1. With no request, HG holds indefinitely and elapsed saturates.
  - HY→AR1 when elapsed = YELLOW_TIME−1.
  - AR1→CG when elapsed = ALL_RED_TIME−1.
  - CG→CY when either (elapsed ≥ CNTRY_MIN_GREEN−1 and X=0) or elapsed = CNTRY_MAX_GREEN−1. The maximum-green cap takes priority even while X=1.
  - CY→AR2 when elapsed = YELLOW_TIME−1.
  - AR2→HG when elapsed = ALL_RED_TIME−1.
- Resulting phase lengths:
  - Fixed phases (HY, AR1, CY, AR2) last exactly their parameter in cycles.
  - HG lasts at least HWY_MIN_GREEN cycles.
  - CG lasts between CNTRY_MIN_GREEN and CNTRY_MAX_GREEN cycles.
- X behaviour:
  - X is ignored in HY, AR1, CY and AR2.
  - A request that arrives and drops during HG before the minimum has elapsed is not latched.
  - X dropping during CG before CNTRY_MIN_GREEN has elapsed does not shorten green.
- Safety invariants:
  - hwy and cntry are never both non-RED in the same cycle.
  - Every green-to-green changeover passes through YELLOW followed by at least one all-RED cycle.
- Simultaneous clear and transition condition: clear wins.

Test Plan:
- Bench parameters: HWY_MIN_GREEN=5, YELLOW_TIME=2, ALL_RED_TIME=1, CNTRY_MIN_GREEN=3, CNTRY_MAX_GREEN=6.
- Reset then X=1 held → phase sequence HG×5, HY×2, AR1×1, CG×6 (max cap), CY×2, AR2×1, then HG again. The full cycle is 17 cycles and repeats while X=1. elapsed counts 0..n−1 in each phase.
- X=0 for 40 cycles after reset → phase stays HG, hwy=2, cntry=0, elapsed=40. Raising X at cycle 40 → HY appears on the following edge.
- In CG, drop X at elapsed=0 → CG lasts exactly 3 cycles (minimum honoured), then CY. Drop X at elapsed=4 → CY on the next edge, so CG lasts 5 cycles.
- Pulse X high for 2 cycles at HG elapsed=1 → no transition; HG persists past 5 cycles.
- Assert clear during CG elapsed=2 → next edge phase=HG, hwy=2, cntry=0, elapsed=0. The safety-invariant assertion holds throughout the run.
- Force the state register to 7 → next edge phase=HG. Lights read GREEN/RED while in code 7.
